// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared by the core datapath blocks.
//   EXECUTE / UPDATE : scheduler core_state encodings observed by the PC unit.
// The reconvergence entry type depends on module parameters, so it is
// declared inside simt_pc_unit.
package gpu_pkg;

  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;

endpackage

// File: rtl/reconv_stack.sv
// reconv_stack: parametrised LIFO holding reconvergence entries.
// Ports:
//   clk, reset         clock, synchronous active-high reset (empties the stack)
//   push, push_data    store push_data on top; ignored when full
//   pop                discard the top entry; ignored when empty
//   top                current top entry ('0 when empty)
//   depth              number of occupied entries
//   full, empty        occupancy flags
// A simultaneous push and pop performs only the push.
module reconv_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    depth_q;

  assign depth = depth_q;
  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (depth_q == CW'(i + 1)) top = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (depth_q == CW'(i)) mem_q[i] <= push_data;
      end
      depth_q <= depth_q + CW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - CW'(1);
    end
  end

endmodule

// File: rtl/simt_pc_unit.sv
// simt_pc_unit: per-core program-counter unit with branch divergence.
// Keeps a per-thread NZP register, an internal active-thread mask and a
// reconvergence stack so threads may take different sides of a BRnzp.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   thread_enable              threads present in the current block
//   core_state                 scheduler state (EXECUTE / UPDATE act)
//   decoded_nzp                branch condition mask
//   decoded_immediate          branch target
//   decoded_nzp_write_enable   CMP result writes NZP in UPDATE
//   decoded_pc_mux             instruction is BRnzp
//   alu_out                    per-thread ALU results, [2:0] of each is NZP
//   current_pc                 PC of the instruction in flight
//   next_pc                    registered next PC
//   active_mask                threads executing at next_pc
//   stack_depth                occupied reconvergence entries
//   stack_overflow             sticky: a divergence needed a push on a full stack
module simt_pc_unit
  import gpu_pkg::*;
#(
  parameter int THREADS               = 4,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [THREADS-1:0]                     thread_enable,
  input  logic [2:0]                             core_state,
  input  logic [2:0]                             decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0]          decoded_immediate,
  input  logic                                   decoded_nzp_write_enable,
  input  logic                                   decoded_pc_mux,
  input  logic [THREADS*DATA_MEM_DATA_BITS-1:0]  alu_out,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]       current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]       next_pc,
  output logic [THREADS-1:0]                     active_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_depth,
  output logic                                   stack_overflow
);

  localparam int T  = THREADS;
  localparam int DW = DATA_MEM_DATA_BITS;
  localparam int PW = PROGRAM_MEM_ADDR_BITS;
  localparam int EW = (DW > PW) ? DW : PW;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [T-1:0]  mask;
  } reconv_entry_t;

  logic [PW-1:0] next_pc_q, next_pc_d;
  logic [T-1:0]  mask_q, mask_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    nzp_q [T];

  logic [T-1:0]  eff, taken, narrow_mask;
  logic [EW-1:0] imm_ext;
  logic [PW-1:0] tgt, inc, reconv_pc, div_pc;
  logic          fwd, first_taken, first_found;

  logic          stack_push, stack_pop, stack_full, stack_empty;
  reconv_entry_t push_entry, top_entry;
  logic [$bits(reconv_entry_t)-1:0] top_bits;

  // Only the NZP slice of each ALU lane is consumed; wide immediates are truncated.
  logic unused_bits;
  assign unused_bits = ^{alu_out, imm_ext};

  assign eff       = mask_q & thread_enable;
  assign imm_ext   = EW'(decoded_immediate);
  assign tgt       = imm_ext[PW-1:0];
  assign inc       = current_pc + PW'(1);
  assign top_entry = top_bits;

  // Forward divergence runs the fall-through side first and reconverges at
  // the target; backward divergence loops the taken side and reconverges
  // at the fall-through.
  assign fwd         = (tgt > current_pc);
  assign reconv_pc   = fwd ? tgt : inc;
  assign div_pc      = fwd ? inc : tgt;
  assign narrow_mask = fwd ? (eff & ~taken) : taken;

  always_comb begin
    taken = '0;
    for (int unsigned t = 0; t < T; t++) begin
      taken[t] = eff[t] & (|(nzp_q[t] & decoded_nzp));
    end
  end

  // Outcome of the lowest-index active thread, used when the stack cannot
  // absorb a divergence.
  always_comb begin
    first_taken = 1'b0;
    first_found = 1'b0;
    for (int unsigned t = 0; t < T; t++) begin
      if (eff[t] && !first_found) begin
        first_taken = taken[t];
        first_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_pc_d  = next_pc_q;
    mask_d     = mask_q;
    ovf_d      = ovf_q;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    push_entry = '0;
    if (core_state == EXECUTE) begin
      next_pc_d = inc;
      if (decoded_pc_mux && (eff != '0)) begin
        if (taken == eff) begin
          next_pc_d = tgt;
        end else if (taken != '0) begin
          if (!stack_empty && (top_entry.pc == reconv_pc)) begin
            mask_d    = narrow_mask;
            next_pc_d = div_pc;
          end else if (stack_full) begin
            ovf_d     = 1'b1;
            next_pc_d = first_taken ? tgt : inc;
          end else begin
            stack_push      = 1'b1;
            push_entry.pc   = reconv_pc;
            push_entry.mask = eff;
            mask_d          = narrow_mask;
            next_pc_d       = div_pc;
          end
        end
      end
      if (!stack_push && !stack_empty && (next_pc_d == top_entry.pc)) begin
        stack_pop = 1'b1;
        mask_d    = top_entry.mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      mask_q    <= '1;
      ovf_q     <= 1'b0;
      for (int unsigned t = 0; t < T; t++) nzp_q[t] <= '0;
    end else begin
      next_pc_q <= next_pc_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      if ((core_state == UPDATE) && decoded_nzp_write_enable) begin
        for (int unsigned t = 0; t < T; t++) begin
          if (eff[t]) nzp_q[t] <= alu_out[t*DW +: 3];
        end
      end
    end
  end

  reconv_stack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH($bits(reconv_entry_t))
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (stack_push),
    .pop      (stack_pop),
    .push_data(push_entry),
    .top      (top_bits),
    .depth    (stack_depth),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  assign next_pc        = next_pc_q;
  assign active_mask    = mask_q & thread_enable;
  assign stack_overflow = ovf_q;

endmodule

// File: tb/tb_simt_pc_unit.sv
// tb_simt_pc_unit: two instances share stimulus; dut_a uses the default
// stack depth, dut_b a single-entry stack for overflow behaviour. The idle
// instance is held in reset. Expected results are queued per cycle and
// compared one cycle later against the selected instance.
module tb_simt_pc_unit;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_EX   = 3'b101;
  localparam logic [2:0] ST_UP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic [3:0]  thread_enable;
  logic [2:0]  core_state, decoded_nzp;
  logic [7:0]  decoded_immediate, current_pc;
  logic        decoded_nzp_write_enable, decoded_pc_mux;
  logic [31:0] alu_out;

  logic [7:0] npc_a, npc_b;
  logic [3:0] mask_a, mask_b;
  logic [2:0] depth_a;
  logic [0:0] depth_b;
  logic       ovf_a, ovf_b;

  always #5 clk = ~clk;

  simt_pc_unit #(.THREADS(4), .DATA_MEM_DATA_BITS(8), .PROGRAM_MEM_ADDR_BITS(8), .STACK_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset_a), .thread_enable(thread_enable), .core_state(core_state),
    .decoded_nzp(decoded_nzp), .decoded_immediate(decoded_immediate),
    .decoded_nzp_write_enable(decoded_nzp_write_enable), .decoded_pc_mux(decoded_pc_mux),
    .alu_out(alu_out), .current_pc(current_pc), .next_pc(npc_a), .active_mask(mask_a),
    .stack_depth(depth_a), .stack_overflow(ovf_a)
  );

  simt_pc_unit #(.THREADS(4), .DATA_MEM_DATA_BITS(8), .PROGRAM_MEM_ADDR_BITS(8), .STACK_DEPTH(1)) dut_b (
    .clk(clk), .reset(reset_b), .thread_enable(thread_enable), .core_state(core_state),
    .decoded_nzp(decoded_nzp), .decoded_immediate(decoded_immediate),
    .decoded_nzp_write_enable(decoded_nzp_write_enable), .decoded_pc_mux(decoded_pc_mux),
    .alu_out(alu_out), .current_pc(current_pc), .next_pc(npc_b), .active_mask(mask_b),
    .stack_depth(depth_b), .stack_overflow(ovf_b)
  );

  typedef struct {
    bit    on_b;
    int    pc;
    int    mask;
    int    depth;
    int    ovf;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   use_b = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Per-thread NZP values packed into alu_out; upper lane bits are noise.
  function automatic logic [31:0] nz(input logic [2:0] t0, input logic [2:0] t1,
                                     input logic [2:0] t2, input logic [2:0] t3);
    return {5'b10101, t3, 5'b10101, t2, 5'b10101, t1, 5'b10101, t0};
  endfunction

  task automatic cyc(input logic [2:0] st, input logic br, input logic [2:0] dn,
                     input logic [7:0] imm, input logic we, input logic [31:0] alu,
                     input logic [7:0] pc, input string tag,
                     input int epc, input int emask, input int edepth, input int eovf);
    exp_t e;
    e.on_b = use_b; e.pc = epc; e.mask = emask; e.depth = edepth; e.ovf = eovf; e.tag = tag;
    sb.push_back(e);
    core_state = st; decoded_pc_mux = br; decoded_nzp = dn; decoded_immediate = imm;
    decoded_nzp_write_enable = we; alu_out = alu; current_pc = pc;
    @(posedge clk);
    #1;
    check({tag, "/sb"}, sb.size(), 1);
    e = sb.pop_front();
    if (e.on_b) begin
      check({e.tag, "/pc"},    int'(npc_b),   e.pc);
      check({e.tag, "/mask"},  int'(mask_b),  e.mask);
      check({e.tag, "/depth"}, int'(depth_b), e.depth);
      check({e.tag, "/ovf"},   int'(ovf_b),   e.ovf);
    end else begin
      check({e.tag, "/pc"},    int'(npc_a),   e.pc);
      check({e.tag, "/mask"},  int'(mask_a),  e.mask);
      check({e.tag, "/depth"}, int'(depth_a), e.depth);
      check({e.tag, "/ovf"},   int'(ovf_a),   e.ovf);
    end
  endtask

  task automatic ex(input logic [7:0] pc, input string tag, input int p, input int m, input int d, input int o);
    cyc(ST_EX, 1'b0, 3'b000, 8'd0, 1'b0, 32'h0, pc, tag, p, m, d, o);
  endtask

  task automatic br(input logic [7:0] pc, input logic [2:0] dn, input logic [7:0] imm, input string tag,
                    input int p, input int m, input int d, input int o);
    cyc(ST_EX, 1'b1, dn, imm, 1'b0, 32'h0, pc, tag, p, m, d, o);
  endtask

  task automatic up(input logic [31:0] alu, input string tag, input int p, input int m, input int d, input int o);
    cyc(ST_UP, 1'b0, 3'b000, 8'd0, 1'b1, alu, 8'd0, tag, p, m, d, o);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; thread_enable = 4'hF;
    use_b = 1'b0;
    cyc(ST_IDLE, 1'b0, 3'b000, 8'd0, 1'b0, 32'h0, 8'd0, "a_reset", 0, 15, 0, 0);
    reset_a = 1'b0;

    ex(8'd5, "nonbranch", 6, 15, 0, 0);
    up(nz(3'b001, 3'b001, 3'b100, 3'b100), "cmp1", 6, 15, 0, 0);
    br(8'd3, 3'b100, 8'd9, "fwd_div", 4, 4'b0011, 1, 0);
    ex(8'd4, "fwd_body", 5, 4'b0011, 1, 0);
    ex(8'd8, "fwd_pop", 9, 15, 0, 0);

    up(nz(3'b010, 3'b010, 3'b001, 3'b001), "cmp2", 9, 15, 0, 0);
    br(8'd6, 3'b010, 8'd2, "bwd_div", 2, 4'b0011, 1, 0);
    ex(8'd2, "bwd_body", 3, 4'b0011, 1, 0);
    ex(8'd6, "bwd_pop", 7, 15, 0, 0);

    br(8'd10, 3'b011, 8'd20, "uni_taken", 20, 15, 0, 0);
    br(8'd10, 3'b100, 8'd77, "uni_fall", 11, 15, 0, 0);

    up(nz(3'b001, 3'b010, 3'b100, 3'b100), "cmp3", 11, 15, 0, 0);
    br(8'd20, 3'b100, 8'd30, "nest_outer", 21, 4'b0011, 1, 0);
    br(8'd22, 3'b010, 8'd30, "nest_merge", 23, 4'b0001, 1, 0);
    ex(8'd29, "merge_pop", 30, 15, 0, 0);

    br(8'd31, 3'b100, 8'd40, "lvl1", 32, 4'b0011, 1, 0);
    br(8'd33, 3'b010, 8'd35, "lvl2", 34, 4'b0001, 2, 0);
    ex(8'd34, "pop_lvl2", 35, 4'b0011, 1, 0);
    ex(8'd39, "pop_lvl1", 40, 15, 0, 0);

    thread_enable = 4'b0111;
    up(nz(3'b001, 3'b001, 3'b001, 3'b001), "te_cmp", 40, 4'b0111, 0, 0);
    thread_enable = 4'hF;
    br(8'd41, 3'b100, 8'd50, "t3_kept", 42, 4'b0111, 1, 0);
    ex(8'd255, "wrap", 0, 4'b0111, 1, 0);

    reset_a = 1'b1;
    br(8'd60, 3'b111, 8'd70, "mid_reset", 0, 15, 0, 0);
    reset_a = 1'b0;
    thread_enable = 4'h0;
    br(8'd12, 3'b111, 8'd77, "eff_zero", 13, 0, 0, 0);
    thread_enable = 4'hF;
    br(8'd12, 3'b111, 8'd77, "nzp_cleared", 13, 15, 0, 0);

    reset_a = 1'b1;
    use_b = 1'b1;
    cyc(ST_IDLE, 1'b0, 3'b000, 8'd0, 1'b0, 32'h0, 8'd0, "b_reset", 0, 15, 0, 0);
    reset_b = 1'b0;
    up(nz(3'b001, 3'b001, 3'b100, 3'b100), "b_cmp1", 0, 15, 0, 0);
    br(8'd3, 3'b100, 8'd9, "b_div", 4, 4'b0011, 1, 0);
    up(nz(3'b100, 3'b001, 3'b100, 3'b100), "b_cmp2", 4, 4'b0011, 1, 0);
    br(8'd5, 3'b100, 8'd20, "b_ovf_t0tk", 20, 4'b0011, 1, 1);
    up(nz(3'b001, 3'b100, 3'b100, 3'b100), "b_cmp3", 20, 4'b0011, 1, 1);
    br(8'd6, 3'b100, 8'd21, "b_ovf_t0nt", 7, 4'b0011, 1, 1);
    ex(8'd8, "b_pop", 9, 15, 0, 1);
    ex(8'd9, "b_sticky", 10, 15, 0, 1);
    reset_b = 1'b1;
    cyc(ST_IDLE, 1'b0, 3'b000, 8'd0, 1'b0, 32'h0, 8'd0, "b_clear", 0, 15, 0, 0);
    reset_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simt_pc_unit.md
# simt_pc_unit

Per-core program-counter unit with branch-divergence support. It replaces the single shared next-PC calculation with per-thread NZP registers, an active-thread mask and a reconvergence stack, so threads in a block can take different sides of a BRnzp and rejoin later. It sits in each core beside the decoder and ALUs. The scheduler consumes `next_pc` and `active_mask` as before.

## Interface
Parameters:
- THREADS, 4, threads per block handled by this core
- DATA_MEM_DATA_BITS, 8, ALU/immediate width
- PROGRAM_MEM_ADDR_BITS, 8, PC width
- STACK_DEPTH, 4, reconvergence stack entries

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- thread_enable  in  THREADS  threads present in the current block
- core_state  in  3  scheduler state; EXECUTE=3'b101, UPDATE=3'b110
- decoded_nzp  in  3  branch condition mask
- decoded_immediate  in  DATA_MEM_DATA_BITS  branch target
- decoded_nzp_write_enable  in  1  CMP writes NZP
- decoded_pc_mux  in  1  instruction is BRnzp
- alu_out  in  THREADS*DATA_MEM_DATA_BITS  per-thread ALU result; thread t uses bits [t*DW +: DW], with [2:0] being NZP
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC of the instruction in flight
- next_pc  out  PROGRAM_MEM_ADDR_BITS  registered next PC
- active_mask  out  THREADS  threads executing at next_pc (internal mask & thread_enable)
- stack_depth  out  $clog2(STACK_DEPTH+1)  occupied entries
- stack_overflow  out  1  sticky error flag

## Operation
- Reset values: next_pc=0, nzp[t]=0 for all t, internal mask all-ones, stack empty, stack_depth=0, stack_overflow=0.
- Definitions:
  - eff = internal mask & thread_enable.
  - taken[t] = eff[t] & |(nzp[t] & decoded_nzp).
  - tgt = decoded_immediate truncated or zero-extended to PROGRAM_MEM_ADDR_BITS.
  - inc = current_pc+1, wrapping modulo 2^PROGRAM_MEM_ADDR_BITS.
- EXECUTE, decoded_pc_mux=0, or eff=0: next_pc=inc. Mask is unchanged.
- EXECUTE, branch, uniform case:
  - taken==eff: next_pc=tgt.
  - taken==0: next_pc=inc.
  - No stack activity.
- EXECUTE, branch, divergent case (0 < taken < eff):
  - Forward branch (tgt > current_pc): push {pc=tgt, mask=eff}. Mask becomes eff & ~taken. next_pc=inc.
  - Backward branch (tgt <= current_pc): push {pc=inc, mask=eff}. Mask becomes taken. next_pc=tgt.
  - Merge rule: if the stack is non-empty and top.pc equals the new reconvergence pc, the push is suppressed. The mask still narrows.
  - Overflow: if the stack is full and a push is required, no push and no mask change. The branch resolves using the outcome of the lowest-index thread in eff. stack_overflow is set until reset.
- Pop: after next_pc is chosen in EXECUTE, if the stack is non-empty and the chosen next_pc equals top.pc, pop the stack and set mask=top.mask on the same edge. At most one pop per EXECUTE. A push and a pop never happen in the same cycle; when a push occurs, the pop check is skipped.
- UPDATE with decoded_nzp_write_enable: for each t with eff[t]=1, nzp[t] <= alu_out[t*DW+2 : t*DW]. Inactive threads keep their NZP.
- Other core_state values: no state change.

## Timing
- next_pc, mask, stack and stack_depth update on the clk edge that ends the EXECUTE cycle. They are valid from the next cycle.
- NZP updates on the edge that ends the UPDATE cycle. A BRnzp in the following instruction sees the new NZP.
- Reset takes priority over everything. Reset mid-divergence empties the stack, restores the all-ones mask and clears stack_overflow.
- A thread_enable change mid-program takes effect immediately through eff. Stack masks are not rewritten.

## Structure
- Shared package `gpu_pkg`:
  - core_state localparams (EXECUTE, UPDATE).
  - typedef reconv_entry_t {pc, mask}. Width is set by the parameters, so it is declared inside the module if the package cannot be parameterised.
- Sub-module `reconv_stack`: parametrised LIFO.
  - Ports: push, pop, push_data, top, depth, full, empty.
  - Synchronous reset. Push when full is ignored. Pop when empty is ignored.

## Test plan
- Reset, then EXECUTE non-branch at current_pc=5 -> next_pc=6, active_mask=1111, stack_depth=0.
- THREADS=4; CMP gives nzp=001,001,100,100; BRn (decoded_nzp=100) to 9 at pc 3 -> next_pc=4, active_mask=0011, depth=1. Later EXECUTE at pc 8 -> next_pc=9, active_mask=1111, depth=0.
- Backward divergence: nzp 010 on threads 0-1 only; BRz to 2 at pc 6 -> next_pc=2, active_mask=0011, top.pc=7. Reaching 7 -> mask 1111, depth 0.
- Nested divergence with equal reconvergence pc -> depth stays 1. Two levels with distinct pcs -> depth 2, then pops in LIFO order.
- STACK_DEPTH=1, second divergent branch -> stack_overflow=1, next_pc follows thread 0's outcome, mask unchanged, flag holds until reset.
- UPDATE with nzp write while thread_enable=0111 -> thread 3 NZP unchanged. Assert reset mid-divergence -> depth=0, next_pc=0, mask=1111.
